// File: rtl/fifo_sync_prog_core.sv
// Storage core: distributed RAM, wrapping pointers and an occupancy count.
// The count, not pointer equality, decides full/empty so every entry is usable.
module fifo_sync_prog_core #(
   parameter int D_WIDTH = 8,
   parameter int A_WIDTH = 5
) (
   input  logic               CLK,
   input  logic               rst_n,
   input  logic [D_WIDTH-1:0] din,
   input  logic               wr_en,
   output logic               full,
   input  logic               rd_en,
   output logic               empty,
   output logic [D_WIDTH-1:0] dout
);

   localparam int DEPTH = 2 ** A_WIDTH;

   logic [D_WIDTH-1:0] ram [DEPTH];
   logic [A_WIDTH-1:0] wr_ptr;
   logic [A_WIDTH-1:0] rd_ptr;
   logic [A_WIDTH:0]   count;
   logic [A_WIDTH:0]   count_next;
   logic               do_write;
   logic               do_read;

   assign do_write = wr_en & ~full;
   assign do_read  = rd_en & ~empty;

   // Next occupancy from accepted requests only.
   always_comb begin
      count_next = count + (A_WIDTH + 1)'(do_write) - (A_WIDTH + 1)'(do_read);
   end

   // RAM write port; contents survive reset, but no write lands in the reset cycle.
   always_ff @(posedge CLK) begin
      if (rst_n && do_write) begin
         ram[wr_ptr] <= din;
      end
   end

   // Pointers, count and registered full/empty flags.
   always_ff @(posedge CLK) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_write) wr_ptr <= wr_ptr + 1'b1;
         if (do_read)  rd_ptr <= rd_ptr + 1'b1;
         count <= count_next;
         full  <= (count_next == (A_WIDTH + 1)'(DEPTH));
         empty <= (count_next == '0);
      end
   end

   assign dout = ram[rd_ptr];

endmodule

// File: rtl/fifo_sync_prog.sv
// First-word-fall-through sync FIFO with optional output register, occupancy
// level, runtime almost-full/almost-empty thresholds and sticky error flags.
module fifo_sync_prog #(
   parameter  int D_WIDTH = -1,
   parameter  int A_WIDTH = 5,
   parameter  int OUT_REG = 0,
   localparam int L_WIDTH = A_WIDTH + 2
) (
   input  logic               CLK,
   input  logic               rst_n,
   input  logic [D_WIDTH-1:0] din,
   input  logic               wr_en,
   output logic               full,
   output logic               almost_full,
   input  logic [L_WIDTH-1:0] af_thresh,
   output logic [D_WIDTH-1:0] dout,
   input  logic               rd_en,
   output logic               empty,
   output logic               almost_empty,
   input  logic [L_WIDTH-1:0] ae_thresh,
   output logic [L_WIDTH-1:0] level,
   output logic               overflow,
   output logic               underflow
);

   logic               core_full;
   logic               core_empty;
   logic               core_rd;
   logic [D_WIDTH-1:0] core_dout;
   logic               do_write;
   logic               do_read;
   logic [L_WIDTH-1:0] level_next;

   fifo_sync_prog_core #(
      .D_WIDTH (D_WIDTH),
      .A_WIDTH (A_WIDTH)
   ) u_core (
      .CLK   (CLK),
      .rst_n (rst_n),
      .din   (din),
      .wr_en (wr_en),
      .full  (core_full),
      .rd_en (core_rd),
      .empty (core_empty),
      .dout  (core_dout)
   );

   // With the output register, full still tracks only the core: the extra
   // word sits in the register and does not block core writes.
   assign full     = core_full;
   assign do_write = wr_en & ~core_full;

   if (OUT_REG == 0) begin : g_direct
      assign core_rd = rd_en;
      assign do_read = rd_en & ~core_empty;
      assign empty   = core_empty;
      assign dout    = core_dout;
   end else begin : g_oreg
      logic               out_valid;
      logic [D_WIDTH-1:0] out_data;

      assign do_read = rd_en & out_valid;
      // Refill whenever the register is vacant or being drained this cycle.
      assign core_rd = (~out_valid | do_read) & ~core_empty;

      // Output register valid bit: refill wins over drain.
      always_ff @(posedge CLK) begin
         if (!rst_n) begin
            out_valid <= 1'b0;
         end else if (core_rd) begin
            out_valid <= 1'b1;
         end else if (do_read) begin
            out_valid <= 1'b0;
         end
      end

      // Output data capture; the valid bit alone qualifies it, so no reset.
      always_ff @(posedge CLK) begin
         if (rst_n && core_rd) begin
            out_data <= core_dout;
         end
      end

      assign empty = ~out_valid;
      assign dout  = out_data;
   end

   // Total words held, including any word parked in the output register.
   always_comb begin
      level_next = level + L_WIDTH'(do_write) - L_WIDTH'(do_read);
   end

   // Level, threshold flags and sticky error flags.
   always_ff @(posedge CLK) begin
      if (!rst_n) begin
         level        <= '0;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         level        <= level_next;
         almost_full  <= (level_next >= af_thresh);
         almost_empty <= (level_next <= ae_thresh);
         overflow     <= overflow  | (wr_en & full);
         underflow    <= underflow | (rd_en & empty);
      end
   end

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Directed bench: one FIFO without and one with the output register,
// both A_WIDTH=3, driven by the same stimulus.
module tb_fifo_sync_prog;

   localparam int DW = 8;
   localparam int AW = 3;
   localparam int LW = AW + 2;

   logic          CLK = 1'b0;
   logic          rst_n = 1'b1;
   logic [DW-1:0] din = '0;
   logic          wr_en = 1'b0;
   logic          rd_en = 1'b0;
   logic [LW-1:0] af_thresh = LW'(6);
   logic [LW-1:0] ae_thresh = LW'(2);

   logic          full0, almost_full0, empty0, almost_empty0, overflow0, underflow0;
   logic [DW-1:0] dout0;
   logic [LW-1:0] level0;
   logic          full1, almost_full1, empty1, almost_empty1, overflow1, underflow1;
   logic [DW-1:0] dout1;
   logic [LW-1:0] level1;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 CLK = ~CLK;

   fifo_sync_prog #(.D_WIDTH(DW), .A_WIDTH(AW), .OUT_REG(0)) dut0 (
      .CLK(CLK), .rst_n(rst_n), .din(din), .wr_en(wr_en), .full(full0),
      .almost_full(almost_full0), .af_thresh(af_thresh), .dout(dout0),
      .rd_en(rd_en), .empty(empty0), .almost_empty(almost_empty0),
      .ae_thresh(ae_thresh), .level(level0), .overflow(overflow0),
      .underflow(underflow0)
   );

   fifo_sync_prog #(.D_WIDTH(DW), .A_WIDTH(AW), .OUT_REG(1)) dut1 (
      .CLK(CLK), .rst_n(rst_n), .din(din), .wr_en(wr_en), .full(full1),
      .almost_full(almost_full1), .af_thresh(af_thresh), .dout(dout1),
      .rd_en(rd_en), .empty(empty1), .almost_empty(almost_empty1),
      .ae_thresh(ae_thresh), .level(level1), .overflow(overflow1),
      .underflow(underflow1)
   );

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      int head;

      // Reset state
      do_reset();
      check_val("rst_empty0", empty0, 1);
      check_val("rst_full0", full0, 0);
      check_val("rst_level0", level0, 0);
      check_val("rst_ae0", almost_empty0, 1);
      check_val("rst_af0", almost_full0, 0);
      check_val("rst_ovf0", overflow0, 0);
      check_val("rst_unf0", underflow0, 0);
      check_val("rst_empty1", empty1, 1);

      // Fill 8 words, no output register; threshold flags follow level
      wr_en = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         din = DW'(i);
         step();
         check_val("fill_level0", level0, i);
         check_val("fill_ae0", almost_empty0, (i <= 2));
         check_val("fill_af0", almost_full0, (i >= 6));
         check_val("fill_full0", full0, (i == 8));
         check_val("fill_head0", dout0, 8'h01);
         check_val("fill_empty0", empty0, 0);
      end
      din = 8'h99;
      step();
      check_val("ovf_set0", overflow0, 1);
      check_val("ovf_level0", level0, 8);
      wr_en = 1'b0;

      // Drain in order
      rd_en = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         check_val("drain_dout0", dout0, i);
         check_val("drain_empty0", empty0, 0);
         step();
         check_val("drain_level0", level0, 8 - i);
         check_val("drain_ae0", almost_empty0, ((8 - i) <= 2));
         check_val("drain_af0", almost_full0, ((8 - i) >= 6));
         check_val("drain_full0", full0, 0);
      end
      check_val("drain_done0", empty0, 1);

      // Read while empty
      step();
      check_val("unf_set0", underflow0, 1);
      check_val("unf_level0", level0, 0);
      check_val("unf_empty0", empty0, 1);
      // Write and read together while empty: only the write lands
      wr_en = 1'b1;
      din = 8'h3C;
      step();
      check_val("wr_rd_empty_level0", level0, 1);
      check_val("wr_rd_empty_dout0", dout0, 8'h3C);
      wr_en = 1'b0;
      step();
      check_val("after_unf_level0", level0, 0);
      check_val("after_unf_empty0", empty0, 1);
      rd_en = 1'b0;

      // Reset mid-transfer with 5 words held
      wr_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         din = DW'(8'h50 + i);
         step();
      end
      check_val("pre_rst_level0", level0, 5);
      check_val("pre_rst_unf0", underflow0, 1);
      rd_en = 1'b1;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      wr_en = 1'b0;
      rd_en = 1'b0;
      check_val("mid_rst_level0", level0, 0);
      check_val("mid_rst_empty0", empty0, 1);
      check_val("mid_rst_ae0", almost_empty0, 1);
      check_val("mid_rst_full0", full0, 0);
      check_val("mid_rst_ovf0", overflow0, 0);
      check_val("mid_rst_unf0", underflow0, 0);
      check_val("mid_rst_level1", level1, 0);
      check_val("mid_rst_empty1", empty1, 1);

      // Output register: one extra cycle of fill latency
      wr_en = 1'b1;
      din = 8'hA5;
      step();
      wr_en = 1'b0;
      check_val("oreg_level_e1", level1, 1);
      check_val("oreg_empty_e1", empty1, 1);
      step();
      check_val("oreg_empty_e2", empty1, 0);
      check_val("oreg_dout", dout1, 8'hA5);
      check_val("oreg_level_e2", level1, 1);
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      check_val("oreg_rd_empty", empty1, 1);
      check_val("oreg_rd_level", level1, 0);

      // Output register: capacity is 9
      do_reset();
      wr_en = 1'b1;
      for (int i = 0; i < 9; i++) begin
         din = DW'(8'h10 + i);
         step();
         check_val("oreg_fill_level", level1, i + 1);
         check_val("oreg_fill_full", full1, (i == 8));
      end
      din = 8'hEE;
      step();
      wr_en = 1'b0;
      check_val("oreg_ovf", overflow1, 1);
      check_val("oreg_ovf_level", level1, 9);
      rd_en = 1'b1;
      for (int i = 0; i < 9; i++) begin
         check_val("oreg_drain_dout", dout1, 8'h10 + i);
         check_val("oreg_drain_empty", empty1, 0);
         step();
         check_val("oreg_drain_level", level1, 8 - i);
      end
      rd_en = 1'b0;
      check_val("oreg_drain_done", empty1, 1);
      check_val("oreg_unf_clear", underflow1, 0);

      // Streaming: 3 words resident, 40 cycles of simultaneous read+write
      do_reset();
      wr_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         din = DW'(i);
         step();
      end
      rd_en = 1'b1;
      head = 0;
      for (int c = 0; c < 40; c++) begin
         din = DW'(3 + c);
         check_val("stream_dout0", dout0, head);
         check_val("stream_dout1", dout1, head);
         step();
         head++;
         check_val("stream_level0", level0, 3);
         check_val("stream_level1", level1, 3);
         check_val("stream_ae0", almost_empty0, 0);
         check_val("stream_af0", almost_full0, 0);
         check_val("stream_full0", full0, 0);
         check_val("stream_empty1", empty1, 0);
      end
      wr_en = 1'b0;
      rd_en = 1'b0;
      check_val("stream_ovf0", overflow0, 0);
      check_val("stream_unf1", underflow1, 0);

      // Threshold limits: 0 forces almost_full, above CAP never asserts
      do_reset();
      af_thresh = '0;
      step();
      check_val("af_zero", almost_full0, 1);
      af_thresh = LW'(9);
      wr_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         din = DW'(i);
         step();
         check_val("af_above_cap", almost_full0, 0);
      end
      wr_en = 1'b0;
      check_val("af_above_cap_full", full0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_sync_prog.md
# fifo_sync_prog

Parametrised synchronous first-word-fall-through FIFO in distributed RAM. It is the general-purpose successor to the small, fast and very-fast sync FIFOs used between pipeline stages. It adds synchronous active-low reset, full 2**A_WIDTH storage, an optional registered output stage, a live occupancy count, runtime-programmable almost-full/almost-empty thresholds, and sticky overflow/underflow flags.

## Interface
Parameters:
- D_WIDTH, -1 (must be overridden), data width in bits.
- A_WIDTH, 5, RAM address width; RAM depth is 2**A_WIDTH.
- OUT_REG, 0, 0 = dout driven combinationally from RAM; 1 = extra output register in front of dout.
- L_WIDTH, derived, A_WIDTH+2; width of the level and threshold ports.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset; one clock, synchronous active-low reset (decided).
- din  in  D_WIDTH  write data.
- wr_en  in  1  write request; accepted only when full=0.
- full  out  1  registered; no write is accepted.
- almost_full  out  1  registered; level >= af_thresh.
- af_thresh  in  L_WIDTH  almost-full threshold, sampled every cycle.
- dout  out  D_WIDTH  head word; valid whenever empty=0.
- rd_en  in  1  read/acknowledge; accepted only when empty=0.
- empty  out  1  registered; dout is not valid.
- almost_empty  out  1  registered; level <= ae_thresh.
- ae_thresh  in  L_WIDTH  almost-empty threshold.
- level  out  L_WIDTH  registered count of words held, including the output register.
- overflow  out  1  sticky; set by wr_en while full.
- underflow  out  1  sticky; set by rd_en while empty.

## Operation
- Capacity CAP = 2**A_WIDTH + OUT_REG.
- Write rule: do_write = wr_en & ~full. Read rule: do_read = rd_en & ~empty.
- Requests that are not accepted have no effect on data or pointers. They only set overflow or underflow.
- The core tracks fullness with a count register of A_WIDTH+1 bits, not pointer equality, so all 2**A_WIDTH RAM entries are usable.
- Pointers wrap modulo 2**A_WIDTH.
- OUT_REG=0: dout = ram[outptr]. empty is 1 when count==0.
- OUT_REG=1: the output register loads from the core when (out_empty | do_read) & ~core_empty.
  - If rd_en is accepted and the core is empty, the output register goes empty.
- Level update: level_next = level + do_write - do_read. Simultaneous accepted read and write leave level unchanged.
- Registered flags are computed from level_next and the current thresholds:
  - full_next = (level_next == CAP) for OUT_REG=0.
  - For OUT_REG=1, full reflects the core count only, with core capacity 2**A_WIDTH.
  - almost_full_next = level_next >= af_thresh.
  - almost_empty_next = level_next <= ae_thresh.
- Threshold limits:
  - af_thresh = 0 forces almost_full=1.
  - af_thresh > CAP means almost_full never asserts.
- Reset (rst_n=0 at a rising edge), including mid-transfer:
  - Pointers, count and level go to 0; empty and almost_empty go to 1.
  - full, almost_full, overflow and underflow go to 0. The output register goes invalid.
  - RAM contents are not cleared.
  - wr_en and rd_en are ignored in the reset cycle.

## Timing
- OUT_REG=0, write into empty at edge n: empty=0 and dout valid after edge n; level=1 after edge n.
- OUT_REG=1, same write: empty=0 after edge n+1. Fill latency is one extra cycle; level counts the word from edge n.
- Read: an accepted rd_en at edge n presents the next word after edge n, or empty=1 if none remains.
- Sustained throughput is one word per cycle in both modes.
- Full, one slot free: wr_en plus an accepted rd_en in the same cycle are both accepted.
- Full, no slot free: wr_en is refused even if rd_en is accepted that cycle, because full is registered.
- Empty with simultaneous wr_en and rd_en: only the write is accepted; underflow is set.
- All outputs are registered except dout in OUT_REG=0 mode.

## Structure
- Sub-module fifo_sync_prog_core: RAM, pointers, count, core full/empty.
- The top level instantiates the core and adds, for OUT_REG=1, the output register and its valid bit, plus level, thresholds and sticky flags.
- No shared package. L_WIDTH and CAP are localparams; nothing is exported.

## Test plan
- A_WIDTH=3, OUT_REG=0: write 8 words 0x01..0x08.
  - full=1 after the 8th edge; level=8.
  - A 9th wr_en sets overflow=1 and leaves level=8.
  - Read all 8: dout=0x01..0x08 in order, then empty=1.
- A_WIDTH=3, OUT_REG=1: single write of 0xA5.
  - empty falls 2 edges after the write; dout=0xA5; level=1 from the first edge.
  - 9 writes fill the FIFO (CAP=9).
- Continuous wr_en and rd_en for 40 cycles with an incrementing pattern: wraps the pointers.
  - Output sequence is unbroken; level is constant; no flag toggles.
- af_thresh=6, ae_thresh=2, A_WIDTH=3: fill one word per cycle.
  - almost_empty falls when level reaches 3.
  - almost_full rises when level reaches 6.
  - Draining mirrors this.
- Assert rst_n=0 for one cycle with level=5 and wr_en=rd_en=1.
  - After the edge: level=0, empty=1, almost_empty=1, full=0, sticky flags cleared, dout invalid.
- rd_en while empty: underflow=1; pointers unchanged. A subsequent write/read pair still returns correct data.
